// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding and parameter defaults for the memory bus controller
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_e;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_N_REQ       = 2;
  localparam int DEF_WAIT_STATES = 1;
  localparam int DEF_TIMEOUT     = 255;
endpackage

// File: rtl/mem_bus_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starts after the last accepted channel
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int PW    = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             accept_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PW-1:0]    idx_o
);
  logic [PW-1:0] ptr_q;
  // scan from farthest to nearest so the nearest requester after the pointer wins
  always_comb begin
    idx_o = '0;
    for (int i = N_REQ; i >= 1; i--)
      if (req_i[PW'((int'(ptr_q) + i) % N_REQ)]) idx_o = PW'((int'(ptr_q) + i) % N_REQ);
    gnt_o = |req_i ? N_REQ'(1) << idx_o : '0;
  end
  // pointer starts at the last channel so channel 0 wins first after reset
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ptr_q <= PW'(N_REQ - 1);
    else if (accept_i) ptr_q <= idx_o;
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: multi-requester multiplexed address/data memory bus controller; WAIT_TIMEOUT_EN adds an nWait timeout abort
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int N_REQ       = DEF_N_REQ,
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic [N_REQ-1:0]        Req,
  input  logic [N_REQ-1:0]        ReqWrite,
  input  logic [N_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [N_REQ*DATA_W-1:0] ReqWData,
  output logic [N_REQ-1:0]        Ack,
  output logic                    Err,
  output logic [DATA_W-1:0]       RData,
  output logic [DATA_W-1:0]       Data_out,
  output logic                    ENB,
  output logic                    ALE,
  output logic                    nME,
  output logic                    nOE,
  output logic                    RnW,
  input  logic [DATA_W-1:0]       Data_in,
  input  logic                    nWait
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, arb_gnt;
  logic [PW-1:0]      gidx_q, arb_idx;
  logic [3:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  wdata;
  logic               wr, accept, at_ws, timed_out;
  assign addr   = ReqAddr[int'(gidx_q)*ADDR_W +: ADDR_W];
  assign wdata  = ReqWData[int'(gidx_q)*DATA_W +: DATA_W];
  assign wr     = ReqWrite[gidx_q];
  assign accept = state_q == IDLE && |Req;
  assign at_ws  = cnt_q == 4'(WAIT_STATES);
  assign Ack    = state_q == DONE ? gnt_q : '0;
  assign RData  = rdata_q;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk_i(Clock), .rst_ni(nReset), .req_i(Req), .accept_i(accept), .gnt_o(arb_gnt), .idx_o(arb_idx)
  );
`ifdef WAIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q;
  logic          err_q, stall;
  assign stall     = state_q == ACCESS && at_ws && !nWait;
  assign timed_out = stall && to_q == TW'(TIMEOUT - 1);
  assign Err       = err_q && state_q == DONE;
  // count consecutive stretched cycles and remember an abort until the bus returns to IDLE
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= stall ? to_q + 1'b1 : '0;
      err_q <= timed_out || (err_q && state_q != IDLE);
    end
`else
  assign timed_out = 1'b0;
  assign Err       = 1'b0;
`endif
  // state, latched grant, access counter and read data registers
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= accept ? arb_gnt : gnt_q;
      gidx_q  <= accept ? arb_idx : gidx_q;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  // next state and bus strobes; strobes idle outside ADDR and ACCESS
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    ALE      = 1'b0;
    nME      = 1'b1;
    nOE      = 1'b1;
    RnW      = 1'b1;
    ENB      = 1'b0;
    Data_out = '0;
    case (state_q)
      IDLE: state_d = |Req ? ADDR : IDLE;
      ADDR: begin
        ALE      = 1'b1;
        nME      = 1'b0;
        ENB      = 1'b1;
        RnW      = ~wr;
        Data_out = DATA_W'(addr);
        cnt_d    = '0;
        state_d  = ACCESS;
      end
      ACCESS: begin
        nME      = 1'b0;
        nOE      = wr;
        ENB      = wr;
        RnW      = ~wr;
        Data_out = wr ? wdata : '0;
        cnt_d    = at_ws ? cnt_q : cnt_q + 4'd1;
        state_d  = (at_ws && nWait) || timed_out ? DONE : ACCESS;
        rdata_d  = at_ws && nWait && !wr ? Data_in : rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: randomized self-checking bench for mem_bus_ctrl against a transaction-level model
module tb_mem_bus_ctrl;
  localparam int DW = 16, AW = 16, N = 2, WS = 1, TO = 8;
  logic            Clock = 1'b0, nReset = 1'b0;
  logic [N-1:0]    Req = '0, ReqWrite = '0;
  logic [N*AW-1:0] ReqAddr = '0;
  logic [N*DW-1:0] ReqWData = '0;
  logic [DW-1:0]   Data_in = '0;
  logic            nWait = 1'b1;
  logic [N-1:0]    Ack;
  logic            Err, ENB, ALE, nME, nOE, RnW;
  logic [DW-1:0]   RData, Data_out;
  int              checks = 0, errors = 0;
  logic [DW-1:0]   rd_model = '0;

  mem_bus_ctrl #(.DATA_W(DW), .ADDR_W(AW), .N_REQ(N), .WAIT_STATES(WS), .TIMEOUT(TO)) dut (
    .Clock(Clock), .nReset(nReset), .Req(Req), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData), .Ack(Ack), .Err(Err), .RData(RData), .Data_out(Data_out), .ENB(ENB),
    .ALE(ALE), .nME(nME), .nOE(nOE), .RnW(RnW), .Data_in(Data_in), .nWait(nWait)
  );

  always #5 Clock = ~Clock;

  task automatic test_reset();
    Req = 2'b11;
    ReqAddr = {16'h2222, 16'h1111};
    #3;
    checks++;
    if ({ALE, nME, nOE, ENB, RnW, Data_out, Ack, Err, RData} !== {5'b01101, 16'h0, 2'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", {ALE, nME, nOE, ENB, RnW, Data_out, Ack, Err, RData},
               {5'b01101, 16'h0, 2'b0, 1'b0, 16'h0});
    end
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  task automatic test_rr();
    logic [N-1:0] mask = 2'b11;
    int last = N - 1, g, n, c;
    bit found;
    for (int t = 0; t < 14; t++) begin
      found = 0;
      g = 0;
      for (int i = 1; i <= N; i++) begin
        c = (last + i) % N;
        if (!found && mask[c]) begin g = c; found = 1; end
      end
      n = 0;
      do begin @(negedge Clock); n++; end while (ALE !== 1'b1 && n < 20);
      checks++;
      if (ALE !== 1'b1 || Data_out !== ReqAddr[g*AW +: AW] || n != (t == 0 ? 1 : 2)) begin
        errors++;
        $display("FAIL rr_grant t=%0d ALE %b addr %h exp %h gap %0d", t, ALE, Data_out, ReqAddr[g*AW +: AW], n);
      end
      n = 0;
      do begin @(negedge Clock); n++; end while (Ack === '0 && n < 20);
      checks++;
      if (Ack !== N'(1 << g) || n != WS + 2) begin
        errors++;
        $display("FAIL rr_ack t=%0d got %b exp %b after %0d cycles exp %0d", t, Ack, N'(1 << g), n, WS + 2);
      end
      last = g;
      if (t >= 4 && $urandom_range(0, 1) == 1) begin
        mask[g] = 1'b0;
        Req[g]  = 1'b0;
      end else ReqAddr[g*AW +: AW] = AW'($urandom);
      if (mask == '0) begin
        c = $urandom_range(0, N - 1);
        mask[c] = 1'b1;
        Req[c]  = 1'b1;
        ReqAddr[c*AW +: AW] = AW'($urandom);
      end
    end
    Req = '0;
    @(negedge Clock);
  endtask

  task automatic run_txn(input int ch, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] din, input int low_from, input int low_len, input bit rnd,
                         input string tag);
    int k = 0;
    logic nw;
    logic [DW-1:0] exp_rd;
    @(negedge Clock);
    Req = '0;
    Req[ch] = 1'b1;
    ReqWrite[ch] = wr;
    ReqAddr[ch*AW +: AW] = a;
    ReqWData[ch*DW +: DW] = wd;
    nWait = 1'b1;
    @(negedge Clock);
    checks++;
    if ({ALE, nME, nOE, ENB, RnW, Data_out, Ack} !== {4'b1011, ~wr, DW'(a), N'(0)}) begin
      errors++;
      $display("FAIL %s addr_phase got %h exp %h", tag, {ALE, nME, nOE, ENB, RnW, Data_out, Ack},
               {4'b1011, ~wr, DW'(a), N'(0)});
    end
    forever begin
      @(negedge Clock);
      checks++;
      if ({ALE, nME, nOE, ENB, RnW, Data_out, Ack} !== {2'b00, wr, wr, ~wr, wr ? wd : DW'(0), N'(0)}) begin
        errors++;
        $display("FAIL %s access_cycle %0d got %h exp %h", tag, k, {ALE, nME, nOE, ENB, RnW, Data_out, Ack},
                 {2'b00, wr, wr, ~wr, wr ? wd : DW'(0), N'(0)});
      end
      nw = rnd ? (k > 20 || $urandom_range(0, 2) != 0) : !(k >= low_from && k < low_from + low_len);
      nWait = nw;
      Data_in = (k >= WS && nw) ? din : DW'($urandom);
      if (k >= WS && nw) break;
      k++;
    end
    exp_rd = wr ? rd_model : din;
    rd_model = exp_rd;
    @(negedge Clock);
    checks++;
    if ({ALE, nME, nOE, ENB, RnW, Data_out, Ack, Err, RData} !== {5'b01101, DW'(0), N'(1 << ch), 1'b0, exp_rd}) begin
      errors++;
      $display("FAIL %s done_phase got %h exp %h", tag, {ALE, nME, nOE, ENB, RnW, Data_out, Ack, Err, RData},
               {5'b01101, DW'(0), N'(1 << ch), 1'b0, exp_rd});
    end
    Req[ch] = 1'b0;
    nWait = 1'b1;
    @(negedge Clock);
    checks++;
    if ({ALE, nME, nOE, ENB, RnW, Ack} !== {5'b01101, N'(0)}) begin
      errors++;
      $display("FAIL %s idle_after got %b", tag, {ALE, nME, nOE, ENB, RnW, Ack});
    end
  endtask

  task automatic test_read();
    run_txn(0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 0, 0, 1'b0, "read");
  endtask

  task automatic test_write();
    run_txn(1, 1'b1, 16'h0040, 16'hA5A5, 16'h0000, 0, 0, 1'b0, "write");
  endtask

  task automatic test_wait();
    run_txn(0, 1'b0, 16'h0F0F, 16'h0000, 16'h5A5A, WS, 5, 1'b0, "wait_rd");
    run_txn(1, 1'b1, 16'h00F0, 16'h3C3C, 16'h0000, WS, 5, 1'b0, "wait_wr");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_txn($urandom_range(0, N - 1), 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), 0, 0, 1'b1, "random");
  endtask

  task automatic test_timeout();
    int n = 0;
    logic [DW-1:0] din = rd_model ^ 16'hFFFF;
    @(negedge Clock);
    Req = 2'b01;
    ReqWrite[0] = 1'b0;
    ReqAddr[AW-1:0] = 16'h0777;
    nWait = 1'b0;
    Data_in = din;
`ifdef WAIT_TIMEOUT_EN
    do begin @(negedge Clock); n++; end while (Ack === '0 && n < 40);
    checks++;
    if (n != 1 + WS + TO + 1 || {ALE, nME, nOE, ENB, RnW, Ack, Err, RData} !== {5'b01101, 2'b01, 1'b1, rd_model}) begin
      errors++;
      $display("FAIL timeout after %0d exp %0d got %h exp %h", n, 2 + WS + TO,
               {ALE, nME, nOE, ENB, RnW, Ack, Err, RData}, {5'b01101, 2'b01, 1'b1, rd_model});
    end
    Req = '0;
    nWait = 1'b1;
    @(negedge Clock);
`else
    do begin @(negedge Clock); n++; end while (Ack === '0 && n < 40);
    checks++;
    if (n != 40 || Ack !== '0 || nME !== 1'b0 || nOE !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout ended after %0d Ack %b nME %b nOE %b", n, Ack, nME, nOE);
    end
    nWait = 1'b1;
    rd_model = din;
    @(negedge Clock);
    checks++;
    if ({Ack, Err, RData, nME} !== {2'b01, 1'b0, din, 1'b1}) begin
      errors++;
      $display("FAIL long_wait_done got %h exp %h", {Ack, Err, RData, nME}, {2'b01, 1'b0, din, 1'b1});
    end
    Req = '0;
    @(negedge Clock);
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge Clock);
    Req = 2'b10;
    ReqWrite[1] = 1'b0;
    ReqAddr[AW +: AW] = 16'h4321;
    nWait = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    checks++;
    if ({ALE, nME, nOE, ENB, RnW, Data_out, Ack, Err, RData} !== {5'b01101, 16'h0, 2'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_mid got %h exp %h", {ALE, nME, nOE, ENB, RnW, Data_out, Ack, Err, RData},
               {5'b01101, 16'h0, 2'b0, 1'b0, 16'h0});
    end
    rd_model = '0;
    Req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++;
      if (Ack !== '0) begin
        errors++;
        $display("FAIL reset_no_ack cycle %0d got %b exp 00", i, Ack);
      end
    end
    nReset = 1'b1;
    run_txn(1, 1'b0, 16'h4321, 16'h0000, 16'hC0DE, 0, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_rr();
    test_read();
    test_write();
    test_wait();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
